// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct codes,
// FSM state type and funct classification helpers.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return f inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  function automatic logic is_unit_op(input logic [5:0] f);
    return is_muldiv(f) || (f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 iterative datapath: shift-add multiply or restoring
// shift-subtract divide, one step per cycle while step is high.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic            done,
  output logic [XLEN-1:0] acc,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITERS);

  logic [XLEN-1:0] opnd;
  logic [CW-1:0]   count;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    add_sum = lo[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
    shifted = {acc, lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
  end

  assign done = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      lo    <= '0;
      opnd  <= '0;
      count <= '0;
    end else if (start) begin
      acc   <= '0;
      lo    <= a_mag;
      opnd  <= b_mag;
      count <= CW'(ITERS - 1);
    end else if (step) begin
      if (is_div) begin
        // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
        if (!diff[XLEN]) begin
          acc <= diff[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], 1'b1};
        end else begin
          acc <= shifted[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        acc <= add_sum[XLEN:1];
        lo  <= {add_sum[0], lo[XLEN-1:1]};
      end
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, sign handling, HI/LO registers and
// the pipeline hold request wrapped around the iterative magnitude core.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int ITERS = XLEN
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            op_valid,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            hold,
  output logic            busy,
  output logic [XLEN-1:0] hilo_rdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t state;
  logic   op_div, neg_res, neg_rem, div0;

  logic            start, signed_op, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            core_done;
  logic [XLEN-1:0] core_acc, core_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] res_hi, res_lo;

  always_comb begin
    start     = op_valid && (state == IDLE) && is_muldiv(funct);
    signed_op = (funct == FN_MULT) || (funct == FN_DIV);
    a_neg     = signed_op && opA[XLEN-1];
    b_neg     = signed_op && opB[XLEN-1];
    a_mag     = a_neg ? -opA : opA;
    b_mag     = b_neg ? -opB : opB;
  end

  muldiv_iter_core #(.XLEN(XLEN), .ITERS(ITERS)) u_core (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .start  (start),
    .step   (state == RUN),
    .is_div (op_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .done   (core_done),
    .acc    (core_acc),
    .lo     (core_lo)
  );

  // Divide by zero forces an all-ones quotient; the remainder path already
  // reproduces opA once the dividend sign is restored.
  always_comb begin
    prod_fix = neg_res ? -{core_acc, core_lo} : {core_acc, core_lo};
    if (op_div) begin
      res_lo = div0 ? '1 : (neg_res ? -core_lo : core_lo);
      res_hi = neg_rem ? -core_acc : core_acc;
    end else begin
      res_lo = prod_fix[XLEN-1:0];
      res_hi = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            op_div  <= (funct == FN_DIV) || (funct == FN_DIVU);
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg && (funct == FN_DIV);
            div0    <= (opB == '0);
          end else if (op_valid && funct == FN_MTHI) begin
            hi <= opA;
          end else if (op_valid && funct == FN_MTLO) begin
            lo <= opA;
          end
        end
        RUN: if (core_done) state <= FIX;
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hold       = op_valid && is_unit_op(funct) && busy;
    hilo_rdata = '0;
    if (op_valid && !busy && funct == FN_MFHI) hilo_rdata = hi;
    if (op_valid && !busy && funct == FN_MFLO) hilo_rdata = lo;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: arithmetic reference model with a
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic            Clk = 1'b0;
  logic            Rst_n = 1'b0;
  logic            op_valid = 1'b0;
  logic [5:0]      funct = '0;
  logic [XLEN-1:0] opA = '0, opB = '0;
  logic            hold, busy;
  logic [XLEN-1:0] hilo_rdata, hi, lo;

  ex_muldiv_unit #(.XLEN(XLEN), .ITERS(XLEN)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .op_valid   (op_valid),
    .funct      (funct),
    .opA        (opA),
    .opB        (opB),
    .hold       (hold),
    .busy       (busy),
    .hilo_rdata (hilo_rdata),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      FN_MULT:  return sa * sb;
      FN_MULTU: begin up = ua * ub; return up; end
      FN_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      FN_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] pend;
  int          m_cnt;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_hi  <= '0;
      m_lo  <= '0;
      m_cnt <= 0;
      pend  <= '0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_hi <= pend[63:32];
        m_lo <= pend[31:0];
      end
    end else if (op_valid) begin
      case (funct)
        FN_MTHI: m_hi <= opA;
        FN_MTLO: m_lo <= opA;
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
          pend  <= ref_result(funct, opA, opB);
          m_cnt <= LAT;
        end
        default: ;
      endcase
    end
  end

  always @(negedge Clk) begin
    logic        e_busy, e_hold;
    logic [31:0] e_rd;
    #2;
    if (Rst_n && cmp_en) begin
      e_busy = (m_cnt != 0);
      e_hold = op_valid && e_busy &&
               (funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                              FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
      e_rd = '0;
      if (op_valid && !e_busy && funct == FN_MFHI) e_rd = m_hi;
      if (op_valid && !e_busy && funct == FN_MFLO) e_rd = m_lo;
      check("cyc_busy", busy, e_busy);
      check("cyc_hold", hold, e_hold);
      check("cyc_rdata", hilo_rdata, e_rd);
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  task automatic drive(input bit v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    op_valid = v;
    funct    = f;
    opA      = a;
    opB      = b;
  endtask

  // Issue one mult/div, then idle the inputs and count busy cycles (bounded).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy);
    drive(1'b1, f, a, b);
    @(negedge Clk);
    op_valid = 1'b0;
    nbusy = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      #1;
      if (!busy) break;
      nbusy++;
      @(negedge Clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n, nohold;
    logic [5:0] fns [8];
    fns = '{FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};

    repeat (2) @(negedge Clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_hold", hold, 1'b0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    @(negedge Clk);
    Rst_n  = 1'b1;
    cmp_en = 1'b1;

    run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_latency", n, LAT);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op(FN_MULT, 32'hFFFF_FFFF, 32'h2, n);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFFE);

    run_op(FN_DIV, 32'hFFFF_FFF9, 32'h2, n);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(FN_DIVU, 32'h7, 32'h2, n);
    check("divu_lo", lo, 32'h3);
    check("divu_hi", hi, 32'h1);

    run_op(FN_DIV, 32'h1234_5678, 32'h0, n);
    check("div0_latency", n, LAT);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234_5678);

    run_op(FN_DIV, 32'h8000_0001, 32'h0, n);
    check("div0_neg_lo", lo, 32'hFFFF_FFFF);
    check("div0_neg_hi", hi, 32'h8000_0001);

    run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("div_ovf_latency", n, LAT);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);

    // MFLO presented throughout a MULT must be held every busy cycle.
    drive(1'b1, FN_MULT, 32'd3, 32'd5);
    @(negedge Clk);
    funct = FN_MFLO;
    n = 0;
    nohold = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      #1;
      if (!busy) break;
      n++;
      if (!hold) nohold++;
      @(negedge Clk);
    end
    check("haz_busy_cycles", n, LAT);
    check("haz_unheld_cycles", nohold, 0);
    check("haz_release_hold", hold, 1'b0);
    check("haz_mflo", hilo_rdata, 32'h0000_000F);

    // A DIV waiting behind a MULTU is accepted on the first idle edge.
    drive(1'b1, FN_MULTU, 32'd7, 32'd9);
    @(negedge Clk);
    funct = FN_DIV;
    opA   = 32'd100;
    opB   = 32'd7;
    n = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      #1;
      if (!busy) break;
      n++;
      @(negedge Clk);
    end
    check("queued_wait_cycles", n, LAT);
    check("queued_first_lo", lo, 32'd63);
    check("queued_idle_hold", hold, 1'b0);
    @(negedge Clk);
    op_valid = 1'b0;
    #1;
    check("queued_accepted", busy, 1'b1);
    for (int k = 0; k < LAT + 8; k++) begin
      #1;
      if (!busy) break;
      @(negedge Clk);
    end
    check("queued_div_lo", lo, 32'd14);
    check("queued_div_hi", hi, 32'd2);

    drive(1'b1, FN_MTHI, 32'hAAAA_0000, 32'h0);
    drive(1'b1, FN_MTLO, 32'h0000_5555, 32'h0);
    drive(1'b1, FN_MFHI, 32'h0, 32'h0);
    #1;
    check("mt_hi", hi, 32'hAAAA_0000);
    check("mt_lo", lo, 32'h0000_5555);
    check("mfhi_same_cycle", hilo_rdata, 32'hAAAA_0000);

    // Reset asserted in the middle of a MULT.
    drive(1'b1, FN_MULT, 32'h1234, 32'h5678);
    repeat (10) @(negedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_hold", hold, 1'b0);
    check("midrun_rst_hi", hi, 32'h0);
    check("midrun_rst_lo", lo, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    funct = FN_MFLO;
    #1;
    check("midrun_rst_mflo", hilo_rdata, 32'h0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge Clk);
      op_valid = ($urandom_range(0, 3) != 0);
      funct    = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 7)] : 6'($urandom());
      opA      = pick();
      opB      = pick();
    end

    drive(1'b0, 6'h0, 32'h0, 32'h0);
    repeat (LAT + 4) @(negedge Clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
